branch_predictor_pht: RTL and testbench

Parametrised pattern-history-table branch predictor. It is the successor to the single 2-bit counter predictor and replaces one shared counter with a table of saturating counters. The table is indexed by PC, or by PC XOR global history in gshare mode. It sits beside the fetch stage: fetch issues lookups, and execute/retire returns resolved outcomes as updates. An internal sweep FSM clears the table after reset, and a saturating mispredict counter is kept for performance monitoring.

---
 rtl/branch_predictor_pht.sv | 190 +++++++++++++++++++
 tb/tb_branch_predictor_pht.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_pht.sv
// Pattern-history-table branch predictor.
// A table of saturating counters is indexed by PC (bimodal) or by PC XOR
// global history (gshare). Lookups answer one cycle later. Resolved
// branches train the table and shift the non-speculative history.
// After reset a sweep fills every entry with weakly-not-taken before
// normal operation begins.
module branch_predictor_pht #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 6,
    parameter int GSHARE     = 1,
    parameter int PC_BITS    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [PC_BITS-1:0]  lookup_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    input  logic                upd_valid,
    input  logic [PC_BITS-1:0]  upd_pc,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic                init_busy,
    output logic [GHR_BITS-1:0] ghr,
    output logic [15:0]         mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
    localparam logic [15:0]           CNT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Table index: PC word bits, optionally folded with zero-extended history.
    function automatic logic [INDEX_BITS-1:0] index_f(
        input logic [INDEX_BITS-1:0] pc_bits,
        input logic [GHR_BITS-1:0]   hist
    );
        logic [INDEX_BITS-1:0] hist_ext;
        hist_ext = '0;
        hist_ext[GHR_BITS-1:0] = hist;
        if (GSHARE != 0) begin
            index_f = pc_bits ^ hist_ext;
        end else begin
            index_f = pc_bits;
        end
    endfunction

    // Saturating up/down step of one prediction counter.
    function automatic logic [CTR_BITS-1:0] ctr_next_f(
        input logic [CTR_BITS-1:0] ctr,
        input logic                taken
    );
        if (taken) begin
            if (ctr == CTR_MAX) begin
                ctr_next_f = ctr;
            end else begin
                ctr_next_f = ctr + CTR_BITS'(1);
            end
        end else begin
            if (ctr == '0) begin
                ctr_next_f = ctr;
            end else begin
                ctr_next_f = ctr - CTR_BITS'(1);
            end
        end
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [INDEX_BITS-1:0] ptr_r;
    logic [CTR_BITS-1:0]   table_r [DEPTH];

    logic                  pred_valid_r;
    logic                  pred_taken_r;
    logic                  init_busy_r;
    logic [GHR_BITS-1:0]   ghr_r;
    logic [15:0]           miss_cnt_r;

    logic [INDEX_BITS-1:0] lookup_idx_s;
    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [CTR_BITS-1:0]   lookup_ctr_s;
    logic [CTR_BITS-1:0]   upd_ctr_s;
    logic [GHR_BITS:0]     ghr_shift_s;
    logic [GHR_BITS-1:0]   ghr_next_s;

    logic                  wr_en_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic [CTR_BITS-1:0]   wr_data_s;

    logic                  unused_pc_bits_s;

    // Both indices use the history as it stood before this cycle's shift.
    assign lookup_idx_s = index_f(lookup_pc[INDEX_BITS+1:2], ghr_r);
    assign upd_idx_s    = index_f(upd_pc[INDEX_BITS+1:2], ghr_r);
    assign lookup_ctr_s = table_r[lookup_idx_s];
    assign upd_ctr_s    = table_r[upd_idx_s];

    // Oldest history bit falls off the top, newest outcome enters at bit 0.
    assign ghr_shift_s  = {ghr_r, upd_taken};
    assign ghr_next_s   = ghr_shift_s[GHR_BITS-1:0];

    assign unused_pc_bits_s = ^{lookup_pc[PC_BITS-1:INDEX_BITS+2], lookup_pc[1:0],
                                upd_pc[PC_BITS-1:INDEX_BITS+2], upd_pc[1:0]};

    assign pred_valid       = pred_valid_r;
    assign pred_taken       = pred_taken_r;
    assign init_busy        = init_busy_r;
    assign ghr              = ghr_r;
    assign mispredict_count = miss_cnt_r;

    // Next state and write-port arbitration: the sweep owns the port in INIT.
    always_comb begin
        state_s   = state_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        wr_data_s = CTR_WNT;
        case (state_r)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = ptr_r;
                wr_data_s = CTR_WNT;
                if (ptr_r == PTR_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                if (upd_valid) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = upd_idx_s;
                    wr_data_s = ctr_next_f(upd_ctr_s, upd_taken);
                end else begin
                    wr_en_s   = 1'b0;
                    wr_idx_s  = ptr_r;
                    wr_data_s = CTR_WNT;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Table write port; contents are only trusted after the sweep completes.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            table_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Control state, prediction response, history and mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_INIT;
            ptr_r        <= '0;
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
            init_busy_r  <= 1'b1;
            ghr_r        <= '0;
            miss_cnt_r   <= 16'h0000;
        end else begin
            state_r      <= state_s;
            init_busy_r  <= (state_s == ST_INIT);
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + INDEX_BITS'(1);
            end
            pred_valid_r <= lookup_valid;
            // Lookups during the sweep answer not-taken; the table read here
            // sees the value before any write at this same edge.
            pred_taken_r <= lookup_valid && (state_r == ST_RUN) && lookup_ctr_s[CTR_BITS-1];
            if ((state_r == ST_RUN) && upd_valid) begin
                ghr_r <= ghr_next_s;
                if (upd_mispredict && (miss_cnt_r != CNT_MAX)) begin
                    miss_cnt_r <= miss_cnt_r + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Bench for branch_predictor_pht: one bimodal and one gshare instance see the
// same stimulus; a behavioural model predicts both, and directed literal
// checks pin the key scenarios.
module tb_branch_predictor_pht;

    localparam int IB    = 4;
    localparam int GB    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;

    logic        pv_b, pt_b, busy_b;
    logic [GB-1:0] ghr_b;
    logic [15:0] cnt_b;
    logic        pv_g, pt_g, busy_g;
    logic [GB-1:0] ghr_g;
    logic [15:0] cnt_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor_pht #(.INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(GB), .GSHARE(0), .PC_BITS(32)) dut_b (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pv_b), .pred_taken(pt_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .init_busy(busy_b), .ghr(ghr_b), .mispredict_count(cnt_b)
    );

    branch_predictor_pht #(.INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(GB), .GSHARE(1), .PC_BITS(32)) dut_g (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pv_g), .pred_taken(pt_g),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .init_busy(busy_g), .ghr(ghr_g), .mispredict_count(cnt_g)
    );

    // ---------------- behavioural model (index 0 = bimodal, 1 = gshare) ----
    int m_tbl [2][DEPTH];
    int m_ghr [2];
    int m_cnt [2];
    int m_init_left;
    bit e_pv;
    bit e_pt [2];
    bit e_busy;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input int inst, input logic [31:0] pc);
        int base;
        base = int'(pc[5:2]);
        if (inst == 1) return base ^ m_ghr[1];
        return base;
    endfunction

    task automatic model_reset();
        m_init_left = DEPTH;
        for (int i = 0; i < 2; i++) begin
            m_ghr[i] = 0;
            m_cnt[i] = 0;
            e_pt[i]  = 1'b0;
        end
        e_pv   = 1'b0;
        e_busy = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_step();
        int li, ui;
        if (rst) begin
            model_reset();
            return;
        end
        e_pv = lookup_valid;
        if (m_init_left > 0) begin
            e_pt[0] = 1'b0;
            e_pt[1] = 1'b0;
            m_init_left--;
            if (m_init_left == 0) begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < DEPTH; j++) m_tbl[i][j] = 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                li = idx_of(i, lookup_pc);
                e_pt[i] = lookup_valid && (m_tbl[i][li] >= 2);
            end
            if (upd_valid) begin
                for (int i = 0; i < 2; i++) begin
                    ui = idx_of(i, upd_pc);
                    if (upd_taken) m_tbl[i][ui] = (m_tbl[i][ui] < 3) ? m_tbl[i][ui] + 1 : 3;
                    else           m_tbl[i][ui] = (m_tbl[i][ui] > 0) ? m_tbl[i][ui] - 1 : 0;
                    m_ghr[i] = ((m_ghr[i] << 1) | int'(upd_taken)) % 16;
                    if (upd_mispredict && m_cnt[i] < 65535) m_cnt[i]++;
                end
            end
        end
        e_busy = (m_init_left > 0);
    endtask

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pred_valid_b", int'(pv_b), int'(e_pv));
            check("pred_valid_g", int'(pv_g), int'(e_pv));
            if (e_pv) begin
                check("pred_taken_b", int'(pt_b), int'(e_pt[0]));
                check("pred_taken_g", int'(pt_g), int'(e_pt[1]));
            end
            check("init_busy_b", int'(busy_b), int'(e_busy));
            check("init_busy_g", int'(busy_g), int'(e_busy));
            check("ghr_b", int'(ghr_b), m_ghr[0]);
            check("ghr_g", int'(ghr_g), m_ghr[1]);
            check("miss_cnt_b", int'(cnt_b), m_cnt[0]);
            check("miss_cnt_g", int'(cnt_g), m_cnt[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input bit um);
        lookup_valid   = lv;
        lookup_pc      = lpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_mispredict = um;
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input bit t, input bit m);
        step(1'b0, 32'h0, 1'b1, pc, t, m);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_now_ghr", int'(ghr_g), 0);
        check("rst_now_cnt", int'(cnt_g), 0);
        check("rst_now_pred_valid", int'(pv_g), 0);
        check("rst_now_busy", int'(busy_b), 1);
        idle();
        idle();
        rst = 1'b0;
    endtask

    task automatic run_init(input bit traffic);
        int busy_seen;
        busy_seen = 0;
        if (busy_b) busy_seen++;
        for (int k = 0; k < 20; k++) begin
            if (traffic && k < 16)
                step(1'b1, 32'h0C + 32'(k * 4), 1'b1, 32'h0C, 1'b1, 1'b1);
            else
                idle();
            if (busy_b) busy_seen++;
            if (traffic && k == 7) begin
                check("init_lookup_valid", int'(pv_b), 1);
                check("init_lookup_taken", int'(pt_g), 0);
            end
        end
        check("init_busy_cycles", busy_seen, DEPTH);
        if (traffic) begin
            check("init_upd_dropped_ghr", int'(ghr_g), 0);
            check("init_upd_dropped_cnt", int'(cnt_b), 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        model_reset();
        #2;
        apply_reset();
        chk_en = 1'b1;
        run_init(1'b1);

        // Gshare aliasing: two taken updates at PC 0x0C make ghr = 0011.
        update(32'h0C, 1'b1, 1'b0);
        update(32'h0C, 1'b1, 1'b0);
        check("gshare_ghr", int'(ghr_g), 3);
        lookup(32'h0C);
        check("gshare_alias_taken", int'(pt_g), 0);
        check("bimodal_idx3_taken", int'(pt_b), 1);

        // Saturation on bimodal entry 0 (PC 0x40), starting at weakly-not-taken.
        update(32'h40, 1'b1, 1'b0);
        update(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        check("sat_after_two_taken", int'(pt_b), 1);
        update(32'h40, 1'b1, 1'b0);
        update(32'h40, 1'b0, 1'b0);
        lookup(32'h40);
        check("sat_high_then_nt", int'(pt_b), 1);
        update(32'h40, 1'b0, 1'b0);
        update(32'h40, 1'b0, 1'b0);
        update(32'h40, 1'b0, 1'b0);
        update(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        check("sat_low_then_taken", int'(pt_b), 0);
        update(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        check("sat_low_two_taken", int'(pt_b), 1);

        // Same-cycle lookup and update of one entry: read-before-write.
        update(32'h44, 1'b1, 1'b0);
        step(1'b1, 32'h44, 1'b1, 32'h44, 1'b0, 1'b0);
        check("hazard_same_cycle", int'(pt_b), 1);
        lookup(32'h44);
        check("hazard_next_cycle", int'(pt_b), 0);

        // Mixed traffic stream checked by the model.
        for (int i = 0; i < 40; i++) begin
            step((i % 3) != 0, 32'(i * 36), (i % 5) != 4, 32'(i * 52 + 8),
                 ((i * 7) % 3) == 0, (i % 4) == 0);
        end

        // Reset in the middle of a stream of updates.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'(i * 4), 1'b1, 32'(i * 8), 1'b1, 1'b1);
        end
        apply_reset();
        run_init(1'b0);

        // Mispredict counter saturation.
        for (int i = 0; i < 65534; i++) begin
            update(32'(i * 4), i[0], 1'b1);
        end
        check("miss_cnt_preload", int'(cnt_b), 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            update(32'h10, 1'b1, 1'b1);
        end
        check("miss_cnt_saturated_g", int'(cnt_g), 16'hFFFF);
        check("miss_cnt_saturated_b", int'(cnt_b), 16'hFFFF);

        idle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
